// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the single-precision multiplier datapath.
// Holds field layout, special encodings and exception flag positions.
package fpu_pkg;

   localparam int          EXP_MAX  = 255;
   localparam int          EXP_BIAS = 127;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // frac[23:1] is the stored mantissa field, frac[0] is the guard bit
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] frac;
   } fp_unpacked_t;

   function automatic logic [31:0] pack_inf(input logic sign);
      return {sign, 8'hFF, 23'h0};
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational classify, round and pack of the multiplier's unpacked result.
// Emits the binary32 word and the exception bits raised by this operand.
module fp_round_pack
   import fpu_pkg::*;
#(
   parameter int ROUND = 1
) (
   input  fp_unpacked_t in_fields,
   input  logic         in_error,
   input  logic         in_overflow,
   output logic [31:0]  word,
   output logic [3:0]   new_bits
);

   logic        round_up;
   logic        frac_nz;
   logic [23:0] m_rnd;
   logic [8:0]  exp_rnd;

   always_comb begin
      round_up = (ROUND == 1) && in_fields.frac[0];
      frac_nz  = |in_fields.frac;
      // A carry into bit 23 leaves m_rnd[22:0] at zero and bumps the exponent
      m_rnd    = {1'b0, in_fields.frac[23:1]} + {23'h0, round_up};
      exp_rnd  = {1'b0, in_fields.exp} + {8'h0, m_rnd[23]};

      word     = '0;
      new_bits = '0;
      if (in_error || (in_fields.exp == 8'hFF && frac_nz)) begin
         word                   = QNAN;
         new_bits[FLAG_INVALID] = 1'b1;
      end else if (in_fields.exp == 8'hFF) begin
         word                    = pack_inf(in_fields.sign);
         new_bits[FLAG_OVERFLOW] = in_overflow;
      end else if (in_fields.exp == 8'h00) begin
         word                     = {in_fields.sign, 31'h0};
         new_bits[FLAG_UNDERFLOW] = frac_nz;
      end else begin
         new_bits[FLAG_INEXACT] = in_fields.frac[0];
         if (exp_rnd >= 9'(EXP_MAX)) begin
            word                    = pack_inf(in_fields.sign);
            new_bits[FLAG_OVERFLOW] = 1'b1;
         end else begin
            word = {in_fields.sign, exp_rnd[7:0], m_rnd[22:0]};
         end
      end
   end

endmodule

// File: rtl/fmul_pack.sv
// Multiplier output stage: round/pack, 2-entry skid buffer, sticky flags and
// output transfer counter. in_ready is a pure register (skid entry empty).
module fmul_pack
   import fpu_pkg::*;
#(
   parameter int ROUND = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [7:0]       in_exp,
   input  logic [23:0]      in_frac,
   input  logic             in_error,
   input  logic             in_overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_word,
   output logic [3:0]       flags,
   input  logic             flag_clr,
   output logic [CNT_W-1:0] out_count
);

   fp_unpacked_t     fields;
   logic [31:0]      packed_word;
   logic [3:0]       new_bits;
   logic             in_xfer;
   logic             out_xfer;

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [31:0]      main_word_q, main_word_d;
   logic [31:0]      skid_word_q, skid_word_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign fields = '{sign: in_sign, exp: in_exp, frac: in_frac};

   fp_round_pack #(.ROUND(ROUND)) u_round_pack (
      .in_fields   (fields),
      .in_error    (in_error),
      .in_overflow (in_overflow),
      .word        (packed_word),
      .new_bits    (new_bits)
   );

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_word  = main_word_q;
   assign flags     = flags_q;
   assign out_count = count_q;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = main_valid_q & out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_word_d  = main_word_q;
      skid_word_d  = skid_word_q;
      if (skid_valid_q) begin
         // in_ready is low here, so only the drain side can move
         if (out_xfer) begin
            main_word_d  = skid_word_q;
            skid_valid_d = 1'b0;
         end
      end else if (!main_valid_q) begin
         if (in_xfer) begin
            main_valid_d = 1'b1;
            main_word_d  = packed_word;
         end
      end else if (in_xfer && out_xfer) begin
         main_word_d = packed_word;
      end else if (out_xfer) begin
         main_valid_d = 1'b0;
      end else if (in_xfer) begin
         skid_valid_d = 1'b1;
         skid_word_d  = packed_word;
      end
      count_d = count_q + CNT_W'(out_xfer);
   end

   // A clear and a same-cycle event on one flag leaves that flag set
   for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign flags_d[gi] = (flags_q[gi] & ~flag_clr) | (new_bits[gi] & in_xfer);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_word_q  <= '0;
         skid_word_q  <= '0;
         flags_q      <= '0;
         count_q      <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_word_q  <= main_word_d;
         skid_word_q  <= skid_word_d;
         flags_q      <= flags_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_fmul_pack.sv
// Scoreboard bench for fmul_pack: a ROUND=1 and a ROUND=0 instance share stimulus;
// a negedge monitor compares both against a FIFO-occupancy and IEEE packing model.
module tb_fmul_pack;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [23:0] in_frac = '0;
   logic        in_error = 1'b0;
   logic        in_overflow = 1'b0;
   logic        out_ready = 1'b1;
   logic        flag_clr = 1'b0;

   logic        in_ready_1, out_valid_1, in_ready_0, out_valid_0;
   logic [31:0] out_word_1, out_word_0;
   logic [3:0]  flags_1, flags_0;
   logic [15:0] out_count_1, out_count_0;

   fmul_pack #(.ROUND(1), .CNT_W(16)) dut_rnd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
      .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_error(in_error),
      .in_overflow(in_overflow), .out_valid(out_valid_1), .out_ready(out_ready),
      .out_word(out_word_1), .flags(flags_1), .flag_clr(flag_clr), .out_count(out_count_1)
   );

   fmul_pack #(.ROUND(0), .CNT_W(16)) dut_trn (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0),
      .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_error(in_error),
      .in_overflow(in_overflow), .out_valid(out_valid_0), .out_ready(out_ready),
      .out_word(out_word_0), .flags(flags_0), .flag_clr(flag_clr), .out_count(out_count_0)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic        done = 1'b0;
   logic        tmo = 1'b0;

   // Reference: value-level packing. Rounding adds one ulp to {exp,mantissa}
   // viewed as a single integer, so a mantissa carry lands in the exponent.
   function automatic void ref_model(input bit rnd, input logic s, input logic [7:0] e,
                                     input logic [23:0] f, input logic err, input logic ovf,
                                     output logic [31:0] w, output logic [3:0] nb);
      logic [30:0] mag;
      nb = 4'b0000;
      if (err || (e == 8'hFF && f != 24'h0)) begin
         w  = 32'h7FC0_0000;
         nb = 4'b1000;
      end else if (e == 8'hFF) begin
         w  = {s, 8'hFF, 23'h0};
         nb = {1'b0, ovf, 2'b00};
      end else if (e == 8'h00) begin
         w  = {s, 31'h0};
         nb = {2'b00, (f != 24'h0), 1'b0};
      end else begin
         mag   = {e, f[23:1]} + 31'(rnd && f[0]);
         nb[0] = f[0];
         if (mag[30:23] == 8'hFF) begin
            w     = {s, 8'hFF, 23'h0};
            nb[2] = 1'b1;
         end else begin
            w = {s, mag};
         end
      end
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
      end
   endfunction

   // Monitor / scoreboard state
   logic [31:0] q1[$];
   logic [31:0] q0[$];
   logic [3:0]  fl1 = 4'h0, fl0 = 4'h0;
   logic [15:0] cnt = 16'h0;
   logic        just_rst = 1'b0;
   int          occ;
   logic        acc;
   logic [31:0] w1, w0;
   logic [3:0]  b1, b0;

   always @(negedge clk) begin
      if (!done) begin
         occ = q1.size();
         chk("out_valid_r1", {31'h0, out_valid_1}, {31'h0, occ > 0});
         chk("out_valid_r0", {31'h0, out_valid_0}, {31'h0, occ > 0});
         chk("in_ready_r1", {31'h0, in_ready_1}, {31'h0, occ < 2});
         chk("in_ready_r0", {31'h0, in_ready_0}, {31'h0, occ < 2});
         if (occ > 0) begin
            chk("word_r1", out_word_1, q1[0]);
            chk("word_r0", out_word_0, q0[0]);
         end
         if (just_rst) begin
            chk("rst_word_r1", out_word_1, 32'h0);
            chk("rst_word_r0", out_word_0, 32'h0);
         end
         chk("flags_r1", {28'h0, flags_1}, {28'h0, fl1});
         chk("flags_r0", {28'h0, flags_0}, {28'h0, fl0});
         chk("count_r1", {16'h0, out_count_1}, {16'h0, cnt});
         chk("count_r0", {16'h0, out_count_0}, {16'h0, cnt});

         if (rst) begin
            q1.delete();
            q0.delete();
            fl1      = 4'h0;
            fl0      = 4'h0;
            cnt      = 16'h0;
            just_rst = 1'b1;
         end else begin
            just_rst = 1'b0;
            if (occ > 0 && out_ready) begin
               $display("OUT #%0d word_r1=%h word_r0=%h", cnt, q1[0], q0[0]);
               void'(q1.pop_front());
               void'(q0.pop_front());
               cnt++;
            end
            acc = in_valid && (occ < 2);
            b1  = 4'h0;
            b0  = 4'h0;
            if (acc) begin
               ref_model(1'b1, in_sign, in_exp, in_frac, in_error, in_overflow, w1, b1);
               ref_model(1'b0, in_sign, in_exp, in_frac, in_error, in_overflow, w0, b0);
               q1.push_back(w1);
               q0.push_back(w0);
            end
            fl1 = (flag_clr ? 4'h0 : fl1) | b1;
            fl0 = (flag_clr ? 4'h0 : fl0) | b0;
         end
      end else begin
         chk("drained", q1.size(), 32'h0);
         chk("no_timeout", {31'h0, tmo}, 32'h0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic s, input logic [7:0] e, input logic [23:0] f,
                       input logic err, input logic ovf, input logic clr);
      int n;
      in_sign     = s;
      in_exp      = e;
      in_frac     = f;
      in_error    = err;
      in_overflow = ovf;
      flag_clr    = clr;
      in_valid    = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready_1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) tmo = 1'b1;
      cycle();
      in_valid = 1'b0;
      flag_clr = 1'b0;
   endtask

   initial begin
      int idx;
      logic [7:0]  stall_e [3];
      stall_e[0] = 8'd130;
      stall_e[1] = 8'd131;
      stall_e[2] = 8'd132;

      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      send(1'b0, 8'd128, 24'h200000, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle();
      send(1'b0, 8'd127, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle();
      send(1'b0, 8'd254, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle();
      send(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b0, 1'b1);
      repeat (3) cycle();

      // Stalled consumer, three back-to-back offers
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         in_sign  = 1'b0;
         in_exp   = stall_e[idx];
         in_frac  = 24'h400002;
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready_1) idx++;
         cycle();
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         in_exp   = stall_e[idx];
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready_1) idx++;
         cycle();
      end
      if (idx < 3) tmo = 1'b1;
      in_valid = 1'b0;
      repeat (4) cycle();

      send(1'b1, 8'h00, 24'h000000, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle();

      // Reset with both entries occupied
      out_ready = 1'b0;
      send(1'b0, 8'd140, 24'h123457, 1'b0, 1'b0, 1'b0);
      send(1'b1, 8'd100, 24'h000001, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (2) cycle();

      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom % 3) != 0;
         in_sign  = 1'($urandom);
         case ($urandom % 6)
            0: in_exp = 8'h00;
            1: in_exp = 8'hFF;
            2: in_exp = 8'd254;
            3: in_exp = 8'd127;
            4: in_exp = 8'd1;
            default: in_exp = 8'($urandom);
         endcase
         case ($urandom % 8)
            0, 1: in_frac = 24'hFFFFFF;
            2:    in_frac = 24'h000000;
            default: in_frac = 24'($urandom);
         endcase
         in_error    = ($urandom % 16) == 0;
         in_overflow = 1'($urandom);
         out_ready   = ($urandom % 4) != 0;
         flag_clr    = ($urandom % 10) == 0;
         rst         = ($urandom % 150) == 0;
         cycle();
      end

      rst       = 1'b0;
      in_valid  = 1'b0;
      flag_clr  = 1'b0;
      out_ready = 1'b1;
      repeat (10) cycle();
      done = 1'b1;
   end

endmodule
